// File: rtl/s420_cmp_sched.sv
// s420_cmp_sched: sequencing controller for the Y-counter / C-threshold
// comparator datapath.
//
// Holds the Y count and the latched C limit. While running, the count advances
// by one on each cycle where tick is high. When the count reaches or passes the
// limit (unsigned), the block raises a match event on a valid/ready output.
// In one-shot mode it then returns to idle. In periodic mode it restarts the
// count. A sticky miss flag records ticks that arrived while the block was not
// counting. A saturating counter records the number of accepted events.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cfg_valid/cfg_ready configuration write handshake (ready only in IDLE)
//   cfg_limit           threshold C, captured on an accepted write
//   cfg_periodic        1 = auto-restart after each hit, 0 = one-shot
//   start, stop         begin a run (IDLE only) / abort a run (RUN or HIT)
//   tick                X qualifier, one increment per cycle while counting
//   busy                high whenever the block is not in IDLE
//   count               current Y count
//   hit_valid/hit_ready match event handshake toward the consumer
//   miss                sticky flag: a tick arrived during a run while not counting
//   ev_count            saturating number of accepted hits since the last start
module s420_cmp_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned EVW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic             miss,
  output logic [EVW-1:0]   ev_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             per_q,   per_d;
  logic             miss_q,  miss_d;
  logic [EVW-1:0]   ev_q,    ev_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      per_q   <= 1'b0;
      miss_q  <= 1'b0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      per_q   <= per_d;
      miss_q  <= miss_d;
      ev_q    <= ev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    per_d   = per_q;
    miss_d  = miss_q;
    ev_d    = ev_q;
    unique case (state_q)
      IDLE: begin
        // A config write in the same cycle as start lands on the same edge.
        // So the new limit is already registered when RUN first compares.
        if (cfg_valid) begin
          limit_d = cfg_limit;
          per_d   = cfg_periodic;
        end
        if (start) begin
          state_d = RUN;
          count_d = '0;
          miss_d  = 1'b0;
          ev_d    = '0;
        end
      end
      RUN: begin
        if (count_q >= limit_q) begin
          // The compare cycle does not count. A tick here is a miss.
          if (tick) miss_d = 1'b1;
          state_d = stop ? IDLE : HIT;
        end else if (stop) begin
          state_d = IDLE;
        end else if (tick) begin
          count_d = count_q + 1'b1;
        end
      end
      HIT: begin
        if (tick) miss_d = 1'b1;
        if (stop) begin
          state_d = IDLE;
        end else if (hit_ready) begin
          if (ev_q != '1) ev_d = ev_q + 1'b1;
          if (per_q) begin
            state_d = RUN;
            count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign hit_valid = (state_q == HIT);
  assign count     = count_q;
  assign miss      = miss_q;
  assign ev_count  = ev_q;

endmodule

// File: tb/tb_s420_cmp_sched.sv
// Directed testbench for s420_cmp_sched. The stimulus process pushes the
// expected contents of each hit into a queue. A monitor process pops the
// queue and compares it whenever a hit handshake completes.
module tb_s420_cmp_sched;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned EVW   = 8;

  logic             clk = 1'b0;
  logic             rst, cfg_valid, cfg_periodic, start, stop, tick, hit_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_ready, busy, hit_valid, miss;
  logic [WIDTH-1:0] count;
  logic [EVW-1:0]   ev_count;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic [EVW-1:0]   ev;
    bit               restart;
  } hit_exp_t;

  hit_exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int pops  = 0;
  bit chk_restart = 1'b0;

  s420_cmp_sched #(.WIDTH(WIDTH), .EVW(EVW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_limit(cfg_limit), .cfg_periodic(cfg_periodic),
    .start(start), .stop(stop), .tick(tick),
    .busy(busy), .count(count),
    .hit_valid(hit_valid), .hit_ready(hit_ready),
    .miss(miss), .ev_count(ev_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [WIDTH-1:0] lim, input logic per);
    cfg_valid = 1'b1; cfg_limit = lim; cfg_periodic = per;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) return;
      step();
    end
    chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: check the restart after a periodic hit, then score each accepted hit.
  always @(negedge clk) begin
    if (chk_restart) begin
      chk("periodic_restart_count", 32'(count), 32'd0);
      chk_restart = 1'b0;
    end
    if (!rst && hit_valid && hit_ready && !stop) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_hit", 32'd1, 32'd0);
      end else begin
        hit_exp_t e;
        e = exp_q.pop_front();
        chk("hit_count", 32'(count), 32'(e.cnt));
        chk("hit_ev_before", 32'(ev_count), 32'(e.ev));
        chk_restart = e.restart;
        pops++;
      end
    end
  end

  initial begin
    hit_exp_t e;
    rst = 1'b1; cfg_valid = 1'b0; cfg_limit = '0; cfg_periodic = 1'b0;
    start = 1'b0; stop = 1'b0; tick = 1'b0; hit_ready = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_hit_valid", {31'd0, hit_valid}, 0);
    chk("rst_busy",      {31'd0, busy}, 0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("rst_count",     32'(count), 0);
    chk("rst_miss",      {31'd0, miss}, 0);
    chk("rst_ev",        32'(ev_count), 0);

    // One-shot, limit 3, tick and hit_ready held high.
    cfg_write(16'd3, 1'b0);
    e.cnt = 16'd3; e.ev = 8'd0; e.restart = 1'b0; exp_q.push_back(e);
    start = 1'b1; tick = 1'b1; hit_ready = 1'b1;
    step();
    start = 1'b0;
    chk("os_busy", {31'd0, busy}, 1);
    chk("os_cnt0", 32'(count), 0);
    step(); chk("os_cnt1", 32'(count), 1);
    step(); chk("os_cnt2", 32'(count), 2);
    step(); chk("os_cnt3", 32'(count), 3);
    chk("os_no_hit_yet", {31'd0, hit_valid}, 0);
    step(); chk("os_hit", {31'd0, hit_valid}, 1);
    step();
    chk("os_hit_drop", {31'd0, hit_valid}, 0);
    chk("os_idle",     {31'd0, busy}, 0);
    chk("os_ev",       32'(ev_count), 1);
    chk("os_miss",     {31'd0, miss}, 1);
    chk("os_cnt_hold", 32'(count), 3);
    tick = 1'b0; hit_ready = 1'b0;

    // limit 0, no ticks, consumer stalls, then reset mid-HIT.
    cfg_write(16'd0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("l0_run_busy", {31'd0, busy}, 1);
    chk("l0_run_nohit", {31'd0, hit_valid}, 0);
    step();
    chk("l0_hit", {31'd0, hit_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("l0_hold_valid", {31'd0, hit_valid}, 1);
      chk("l0_hold_count", 32'(count), 0);
      chk("l0_hold_miss",  {31'd0, miss}, 0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_hit_valid", {31'd0, hit_valid}, 0);
    chk("mrst_busy",      {31'd0, busy}, 0);
    chk("mrst_count",     32'(count), 0);
    chk("mrst_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("mrst_miss",      {31'd0, miss}, 0);

    // stop together with hit_ready, and start ignored during RUN.
    cfg_write(16'd1, 1'b0);
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b1;              // start again while RUN: must not restart count
    step();
    start = 1'b0; tick = 1'b0;
    chk("sv_count_after_start", 32'(count), 1);
    step();
    chk("sv_hit", {31'd0, hit_valid}, 1);
    stop = 1'b1; hit_ready = 1'b1;
    step();
    stop = 1'b0; hit_ready = 1'b0;
    chk("sv_busy",      {31'd0, busy}, 0);
    chk("sv_hit_drop",  {31'd0, hit_valid}, 0);
    chk("sv_ev",        32'(ev_count), 0);
    chk("sv_count",     32'(count), 1);

    // Config gating: a write during RUN is refused.
    cfg_write(16'd2, 1'b0);
    e.cnt = 16'd2; e.ev = 8'd0; e.restart = 1'b0; exp_q.push_back(e);
    start = 1'b1; tick = 1'b1; hit_ready = 1'b1;
    step();
    start = 1'b0;
    cfg_valid = 1'b1; cfg_limit = 16'd7;
    chk("cg_ready_run", {31'd0, cfg_ready}, 0);
    step();
    cfg_valid = 1'b0;
    wait_idle(20);
    chk("cg_limit_kept", 32'(count), 2);
    // The same write in IDLE together with start applies to this run.
    cfg_valid = 1'b1; cfg_limit = 16'd7; cfg_periodic = 1'b0; start = 1'b1;
    e.cnt = 16'd7; e.ev = 8'd0; e.restart = 1'b0; exp_q.push_back(e);
    step();
    cfg_valid = 1'b0; start = 1'b0;
    wait_idle(30);
    chk("cg_count7", 32'(count), 7);
    chk("cg_ev",     32'(ev_count), 1);
    tick = 1'b0;

    // Periodic, limit 2, tick every other cycle, 300 hits.
    cfg_write(16'd2, 1'b1);
    for (int k = 0; k < 300; k++) begin
      e.cnt = 16'd2; e.ev = (k > 255) ? 8'd255 : 8'(k); e.restart = 1'b1;
      exp_q.push_back(e);
    end
    pops = 0;
    start = 1'b1; hit_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 5000 && pops < 300; c++) begin
      tick = ~tick;
      step();
    end
    chk("per_hits", pops, 300);
    tick = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0; hit_ready = 1'b0;
    step();
    chk("per_busy", {31'd0, busy}, 0);
    chk("per_ev_sat", 32'(ev_count), 255);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s420_cmp_sched.md
Name: s420_cmp_sched

Overview:
- Sequencing controller for the 16-bit Y-counter / C-threshold comparator datapath.
- Owns the Y count register and the latched C limit, and advances the count on qualified X ticks.
- Detects `count >= limit` (unsigned) and delivers each match as a valid/ready event to a downstream consumer.
- Supports one-shot and periodic (auto-restart) scheduling, sticky missed-tick reporting and a saturating delivered-event counter.

Parameters:
- WIDTH, 16, width of count and limit.
- EVW, 8, width of delivered-event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  high only in IDLE; write accepted when cfg_valid&&cfg_ready.
- cfg_limit  in  WIDTH  threshold C, captured on accepted write.
- cfg_periodic  in  1  1=periodic, 0=one-shot, captured with cfg_limit.
- start  in  1  begin a run; honoured only in IDLE.
- stop  in  1  abort; honoured in RUN or HIT.
- tick  in  1  X qualifier; one count increment per cycle while RUN.
- busy  out  1  state != IDLE.
- count  out  WIDTH  current Y count.
- hit_valid  out  1  match event pending (state HIT).
- hit_ready  in  1  consumer accepts event.
- miss  out  1  sticky: a tick arrived while not counting during a run.
- ev_count  out  EVW  saturating number of accepted hits since last start.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, count=0, limit=0, periodic=0, miss=0, ev_count=0.
  - Outputs: hit_valid=0, busy=0, cfg_ready=1.
  - rst overrides every other input in any state, including mid-run and mid-handshake. No hit is delivered after rst.
- States:
  - IDLE: cfg_ready=1.
  - RUN: busy=1.
  - HIT: busy=1, hit_valid=1.
- IDLE:
  - Accepted cfg write updates limit/periodic next edge.
  - start moves to RUN with count=0, miss=0, ev_count=0.
  - cfg write and start in the same cycle: the new cfg applies to this run.
  - tick is ignored.
- RUN, compare on the registered count each cycle:
  - If count>=limit: go to HIT. A tick in this same cycle is not counted and sets miss.
  - Else: tick increments count by 1. No wrap is possible, because count stops at limit ≤ 2^WIDTH-1.
  - limit=0: HIT is entered one cycle after entering RUN.
- HIT:
  - hit_valid stays high, and count holds, until hit_valid&&hit_ready.
  - Any tick while in HIT sets miss.
  - On handshake, ev_count increments, saturating at 2^EVW-1.
  - On handshake with periodic=1: next state RUN, count=0.
  - On handshake with periodic=0: next state IDLE, count holds its final value.
- stop in RUN or HIT: next state IDLE, hit_valid drops next cycle.
  - stop has priority over a simultaneous handshake; that hit is not counted.
  - count holds.
- start in RUN or HIT is ignored. cfg_valid outside IDLE is not accepted (cfg_ready=0).
- Latency, limit=L, ticks every cycle from cycle s+1 (start sampled at s):
  - count=L at edge s+L+1.
  - hit_valid high from cycle s+L+2.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

Test Plan:
- Reset mid-HIT: with hit_valid=1, assert rst for 1 cycle -> next cycle hit_valid=0, busy=0, count=0, cfg_ready=1, miss=0.
- One-shot, limit=3: write cfg, start at cycle 10, tick=1 continuously, hit_ready=1 -> count 1,2,3 at cycles 12,13,14. hit_valid high cycle 15 only. ev_count=1, state IDLE at 16. miss=1 (tick during compare/HIT cycles).
- Periodic, limit=2: tick every other cycle, hit_ready=1 -> hit_valid pulses repeatedly; count restarts from 0 after each accept. ev_count increments per hit, saturating at 255 after 300 hits.
- limit=0 with tick=0: start -> RUN for 1 cycle, then hit_valid=1. Hold hit_ready=0 for 5 cycles -> hit_valid stays 1, count stays 0, miss=0.
- stop vs handshake: in HIT assert stop and hit_ready together -> IDLE next cycle, ev_count unchanged. start issued during RUN has no effect on count.
- Config gating: cfg_valid with limit=7 during RUN -> cfg_ready=0, limit unchanged. Same write in IDLE together with start -> run uses limit=7 (hit after count=7).
